character_btn_ctrl: RTL and testbench

Input conditioning stage directly upstream of the character physics/FSM block. Synchronises and debounces the three raw push-buttons (left, right, jump) and applies movement arbitration. Emits clean levels and one-cycle press pulses, plus a jump-hold counter with release strobe that the character block uses for charge timing. Runs on the character tick clock, so all outputs are stable for a whole game tick.

---
 rtl/character_pkg.sv | 15 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/character_btn_ctrl.sv | 145 ++++++++++++++
 tb/tb_character_btn_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/character_pkg.sv
// Shared definitions for the character input path and the character physics block.
// Defaults live here so both blocks agree on the jump charge limit.
package character_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_MAX_HOLD        = 100;

    typedef enum logic [1:0] {
        J_IDLE    = 2'd0,
        J_HOLD    = 2'd1,
        J_RELEASE = 2'd2
    } jump_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: multi-flop synchroniser followed by a disagreement-count debouncer.
// The level only flips after DEBOUNCE_CYCLES consecutive samples disagree with it.
module btn_debounce
    import character_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic character_clk,
    input  logic sys_rst_n,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s_x;

    assign s_x = sync[SYNC_STAGES-1];

    always_ff @(posedge character_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge character_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s_x == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/character_btn_ctrl.sv
// Button conditioning for the character block: debounce, left/right/jump arbitration,
// press strobes and a saturating jump-hold counter with a release strobe.
//
//   state     | meaning
//   J_IDLE    | jump not held, hold_cnt = 0
//   J_HOLD    | jump held, hold_cnt counting up to MAX_HOLD
//   J_RELEASE | release strobe cycle, hold_cnt still shows the final hold length
module character_btn_ctrl
    import character_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MAX_HOLD        = DEF_MAX_HOLD,
    localparam int HOLD_W         = $clog2(MAX_HOLD + 1)
) (
    input  logic              character_clk,
    input  logic              sys_rst_n,
    input  logic              enable,
    input  logic              raw_left,
    input  logic              raw_right,
    input  logic              raw_jump,
    output logic              left_btn,
    output logic              right_btn,
    output logic              jump_btn,
    output logic              left_pulse,
    output logic              right_pulse,
    output logic              jump_pulse,
    output logic              jump_release_pulse,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              hold_max
);

    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);

    logic db_left, db_right, db_jump;
    logic next_left, next_right, next_jump;

    jump_state_t       state, state_next;
    logic [HOLD_W-1:0] cnt_next;
    logic              release_next;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .character_clk (character_clk),
        .sys_rst_n     (sys_rst_n),
        .raw           (raw_left),
        .level         (db_left)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .character_clk (character_clk),
        .sys_rst_n     (sys_rst_n),
        .raw           (raw_right),
        .level         (db_right)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_jump (
        .character_clk (character_clk),
        .sys_rst_n     (sys_rst_n),
        .raw           (raw_jump),
        .level         (db_jump)
    );

    // Opposing directions cancel, and jump suppresses both directions.
    assign next_left  = db_left  & ~db_right & ~db_jump & enable;
    assign next_right = db_right & ~db_left  & ~db_jump & enable;
    assign next_jump  = db_jump  & enable;

    always_ff @(posedge character_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            left_btn    <= 1'b0;
            right_btn   <= 1'b0;
            jump_btn    <= 1'b0;
            left_pulse  <= 1'b0;
            right_pulse <= 1'b0;
            jump_pulse  <= 1'b0;
        end else begin
            left_btn    <= next_left;
            right_btn   <= next_right;
            jump_btn    <= next_jump;
            left_pulse  <= next_left  & ~left_btn;
            right_pulse <= next_right & ~right_btn;
            jump_pulse  <= next_jump  & ~jump_btn;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = hold_cnt;
        release_next = 1'b0;
        if (!enable) begin
            // Disabling abandons the hold silently; no release strobe.
            state_next = J_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                J_IDLE: begin
                    if (next_jump) begin
                        state_next = J_HOLD;
                        cnt_next   = HOLD_W'(1);
                    end else begin
                        cnt_next = '0;
                    end
                end
                J_HOLD: begin
                    if (next_jump) begin
                        if (hold_cnt != HOLD_SAT) begin
                            cnt_next = hold_cnt + HOLD_W'(1);
                        end
                    end else begin
                        state_next   = J_RELEASE;
                        release_next = 1'b1;
                    end
                end
                J_RELEASE: begin
                    if (next_jump) begin
                        state_next = J_HOLD;
                        cnt_next   = HOLD_W'(1);
                    end else begin
                        state_next = J_IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = J_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge character_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state              <= J_IDLE;
            hold_cnt           <= '0;
            hold_max           <= 1'b0;
            jump_release_pulse <= 1'b0;
        end else begin
            state              <= state_next;
            hold_cnt           <= cnt_next;
            hold_max           <= (cnt_next == HOLD_SAT);
            jump_release_pulse <= release_next;
        end
    end

endmodule

// File: tb/tb_character_btn_ctrl.sv
// Bench for character_btn_ctrl: directed scenarios plus random button traffic, all
// compared every cycle against a behavioural model of the conditioned outputs.
module tb_character_btn_ctrl;
    import character_pkg::*;

    localparam int SYNC = DEF_SYNC_STAGES;
    localparam int DEB  = DEF_DEBOUNCE_CYCLES;
    localparam int MAXH = DEF_MAX_HOLD;
    localparam int HW   = $clog2(MAXH + 1);

    logic          character_clk = 1'b0;
    logic          sys_rst_n;
    logic          enable;
    logic          raw_left, raw_right, raw_jump;
    logic          left_btn, right_btn, jump_btn;
    logic          left_pulse, right_pulse, jump_pulse;
    logic          jump_release_pulse;
    logic [HW-1:0] hold_cnt;
    logic          hold_max;

    int total = 0;
    int bad   = 0;

    // Model state: index 0 = left, 1 = right, 2 = jump
    logic m_sync [3][SYNC];
    logic m_win  [3][DEB];
    logic m_db   [3];
    logic m_left, m_right, m_jump, m_lp, m_rp, m_jp, m_rel;
    int   m_hold;

    character_btn_ctrl dut (
        .character_clk      (character_clk),
        .sys_rst_n          (sys_rst_n),
        .enable             (enable),
        .raw_left           (raw_left),
        .raw_right          (raw_right),
        .raw_jump           (raw_jump),
        .left_btn           (left_btn),
        .right_btn          (right_btn),
        .jump_btn           (jump_btn),
        .left_pulse         (left_pulse),
        .right_pulse        (right_pulse),
        .jump_pulse         (jump_pulse),
        .jump_release_pulse (jump_release_pulse),
        .hold_cnt           (hold_cnt),
        .hold_max           (hold_max)
    );

    always #5 character_clk = ~character_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < SYNC; i++) m_sync[c][i] = 1'b0;
            for (int i = 0; i < DEB; i++) m_win[c][i] = 1'b0;
            m_db[c] = 1'b0;
        end
        {m_left, m_right, m_jump, m_lp, m_rp, m_jp, m_rel} = '0;
        m_hold = 0;
    endtask

    // One clock edge of the specified behaviour, from the pre-edge state.
    task automatic model_clock();
        logic       nl, nr, nj, s, all_diff;
        logic [2:0] raw_v;
        raw_v = {raw_jump, raw_right, raw_left};
        nl = m_db[0] & ~m_db[1] & ~m_db[2] & enable;
        nr = m_db[1] & ~m_db[0] & ~m_db[2] & enable;
        nj = m_db[2] & enable;
        m_lp = nl & ~m_left;
        m_rp = nr & ~m_right;
        m_jp = nj & ~m_jump;
        if (nj) begin
            m_hold = m_jump ? ((m_hold < MAXH) ? m_hold + 1 : MAXH) : 1;
            m_rel  = 1'b0;
        end else if (m_jump && enable) begin
            m_rel = 1'b1;
        end else begin
            m_rel  = 1'b0;
            m_hold = 0;
        end
        m_left  = nl;
        m_right = nr;
        m_jump  = nj;
        for (int c = 0; c < 3; c++) begin
            s = m_sync[c][SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_sync[c][i] = m_sync[c][i-1];
            m_sync[c][0] = raw_v[c];
            for (int i = DEB - 1; i > 0; i--) m_win[c][i] = m_win[c][i-1];
            m_win[c][0] = s;
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) if (m_win[c][i] == m_db[c]) all_diff = 1'b0;
            if (all_diff) m_db[c] = ~m_db[c];
        end
    endtask

    task automatic check_all();
        chk("left_btn",     32'(left_btn),           32'(m_left));
        chk("right_btn",    32'(right_btn),          32'(m_right));
        chk("jump_btn",     32'(jump_btn),           32'(m_jump));
        chk("left_pulse",   32'(left_pulse),         32'(m_lp));
        chk("right_pulse",  32'(right_pulse),        32'(m_rp));
        chk("jump_pulse",   32'(jump_pulse),         32'(m_jp));
        chk("release",      32'(jump_release_pulse), 32'(m_rel));
        chk("hold_cnt",     32'(hold_cnt),           32'(m_hold));
        chk("hold_max",     32'(hold_max),           32'(m_hold == MAXH));
    endtask

    task automatic step();
        @(posedge character_clk);
        if (sys_rst_n) model_clock();
        #1;
        check_all();
    endtask

    initial begin
        int cnt_a, cnt_b;
        sys_rst_n = 1'b0;
        enable    = 1'b1;
        raw_left  = 1'b0;
        raw_right = 1'b0;
        raw_jump  = 1'b0;
        model_reset();
        #2;
        check_all();
        #10 sys_rst_n = 1'b1;
        repeat (5) step();

        // Glitch of 3 samples on left never reaches the outputs
        step();
        raw_left = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 3) raw_left = 1'b0;
            chk("glitch_level", 32'(left_btn), 32'(0));
            chk("glitch_pulse", 32'(left_pulse), 32'(0));
        end

        // Clean press: raw rises just after edge 0, drops just after edge 20
        step();
        raw_left = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            step();
            if (e == 20) raw_left = 1'b0;
            chk("press_level", 32'(left_btn), 32'(e >= 7 && e < 27));
            chk("press_pulse", 32'(left_pulse), 32'(e == 7));
        end

        // Conflict between left and right
        raw_left = 1'b1;
        repeat (15) step();
        raw_right = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            chk("conflict_right", 32'(right_btn), 32'(0));
        end
        chk("conflict_left_off", 32'(left_btn), 32'(0));
        raw_left = 1'b0;
        cnt_a = 0;
        for (int e = 1; e <= 15; e++) begin
            step();
            if (right_pulse) cnt_a++;
        end
        chk("conflict_right_on", 32'(right_btn), 32'(1));
        chk("conflict_rpulses", 32'(cnt_a), 32'(1));
        raw_right = 1'b0;
        repeat (12) step();

        // Jump held 30 cycles with left pressed alongside
        step();
        raw_jump = 1'b1;
        raw_left = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int e = 1; e <= 45; e++) begin
            step();
            if (e == 30) begin
                raw_jump = 1'b0;
                raw_left = 1'b0;
            end
            if (jump_pulse) cnt_a++;
            if (jump_release_pulse) cnt_b++;
            chk("hold30_cnt", 32'(hold_cnt),
                (e >= 7 && e <= 36) ? 32'(e - 6) : ((e == 37) ? 32'(30) : 32'(0)));
            chk("hold30_rel", 32'(jump_release_pulse), 32'(e == 37));
            chk("hold30_left", 32'(left_btn), 32'(0));
        end
        chk("hold30_jpulses", 32'(cnt_a), 32'(1));
        chk("hold30_rpulses", 32'(cnt_b), 32'(1));

        // Saturation: 150 held cycles
        raw_jump = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int e = 1; e <= 165; e++) begin
            step();
            if (e == 150) raw_jump = 1'b0;
            if (hold_max && jump_btn) cnt_a++;
            if (jump_release_pulse) begin
                cnt_b++;
                chk("sat_rel_cnt", 32'(hold_cnt), 32'(MAXH));
            end
        end
        chk("sat_max_cycles", 32'(cnt_a), 32'(51));
        chk("sat_rpulses", 32'(cnt_b), 32'(1));

        // Disable mid-hold, re-enable while still held, then reset mid-hold
        raw_jump = 1'b1;
        repeat (20) step();
        enable = 1'b0;
        step();
        chk("dis_jump", 32'(jump_btn), 32'(0));
        chk("dis_cnt", 32'(hold_cnt), 32'(0));
        chk("dis_rel", 32'(jump_release_pulse), 32'(0));
        repeat (3) step();
        enable = 1'b1;
        step();
        chk("reen_pulse", 32'(jump_pulse), 32'(1));
        chk("reen_cnt", 32'(hold_cnt), 32'(1));
        repeat (5) step();
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_jump", 32'(jump_btn), 32'(0));
        step();
        #1 sys_rst_n = 1'b1;
        repeat (12) step();
        raw_jump = 1'b0;
        repeat (12) step();

        // Random traffic including short glitches and enable drops
        for (int seg = 0; seg < 60; seg++) begin
            raw_left  = 1'($urandom_range(0, 1));
            raw_right = 1'($urandom_range(0, 1));
            raw_jump  = ($urandom_range(0, 2) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(1, 30)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
